// File: rtl/hazard_sb_pkg.sv
// hazard_sb_pkg: shared result-class, tag type and availability lookup for the hazard scoreboard
package hazard_sb_pkg;
  localparam int RD_W = 8;
  typedef enum logic [1:0] {LAT_ALU = 2'd0, LAT_LOAD = 2'd1, LAT_CP0 = 2'd2} lat_e;
  typedef struct packed {
    logic v;
    logic [RD_W-1:0] rd;
    lat_e lat;
  } tag_t;
  function automatic int unsigned avail_of(lat_e lat, int unsigned load_avail, int unsigned cp0_avail);
    return lat == LAT_LOAD ? load_avail : lat == LAT_CP0 ? cp0_avail : 0;
  endfunction
endpackage

// File: rtl/hazard_sb_tagpipe.sv
// hazard_sb_tagpipe: shadow pipeline of destination tags with ES hold and bubble insertion
module hazard_sb_tagpipe import hazard_sb_pkg::*; #(
  parameter int NSTAGE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic hold,
  input  tag_t tag_in,
  output tag_t [NSTAGE-1:0] tags
);
  // ES keeps its tag while held and a bubble enters stage 1 behind it
  always_ff @(posedge clk) begin
    if (reset || flush) tags <= '0;
    else begin
      tags[0] <= hold ? tags[0] : tag_in;
      for (int i = 1; i < NSTAGE; i++) tags[i] <= (hold && i == 1) ? '0 : tags[i-1];
    end
  end
endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: scoreboard hazard unit producing stall/bubble/flush controls and a stall counter
module hazard_sb import hazard_sb_pkg::*; #(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned CP0_AVAIL  = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds_valid,
  input  logic [REG_W-1:0] ds_rs1,
  input  logic [REG_W-1:0] ds_rs2,
  input  logic             ds_br,
  input  logic [REG_W-1:0] ds_rd,
  input  logic             ds_reg_write,
  input  logic [1:0]       ds_lat,
  input  logic             ds_is_div,
  input  logic             mem_data_ok,
  input  logic             exc_flush,
  output logic             fs_stall,
  output logic             ds_stall,
  output logic             es_stall,
  output logic             es_bubble,
  output logic             fs_flush,
  output logic             ds_flush,
  output logic             es_flush,
  output logic             post_flush,
  output logic [31:0]      stall_cnt
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  tag_t [NSTAGE-1:0] tags;
  tag_t tag_in;
  logic [CW-1:0] div_cnt;
  logic hz, issue;

  function automatic logic hit(tag_t t, int unsigned i, logic [REG_W-1:0] s);
    int unsigned av;
    av = avail_of(t.lat, LOAD_AVAIL, CP0_AVAIL);
    return ds_valid && s != '0 && t.v && t.rd == RD_W'(s) &&
           (ds_br ? i <= av : (i < av || (i == av && t.lat == LAT_LOAD && !mem_data_ok)));
  endfunction

  // OR of every source-vs-stage hazard across the shadow pipeline
  always_comb begin
    hz = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) hz = hz | hit(tags[i], i, ds_rs1) | hit(tags[i], i, ds_rs2);
  end

  assign es_stall   = div_cnt != '0 && !exc_flush;
  assign ds_stall   = !exc_flush && (hz || es_stall);
  assign fs_stall   = ds_stall;
  assign es_bubble  = hz && !es_stall && !exc_flush;
  assign fs_flush   = exc_flush;
  assign ds_flush   = exc_flush;
  assign es_flush   = exc_flush;
  assign post_flush = exc_flush;
  assign issue      = ds_valid && !ds_stall && !exc_flush;
  assign tag_in     = '{v: issue && ds_reg_write, rd: RD_W'(ds_rd), lat: lat_e'(ds_lat)};

  hazard_sb_tagpipe #(.NSTAGE(NSTAGE)) u_tagpipe (
    .clk(clk),
    .reset(reset),
    .flush(exc_flush),
    .hold(es_stall),
    .tag_in(tag_in),
    .tags(tags)
  );

  // divider occupancy: reload on div issue, count down to idle
  always_ff @(posedge clk) begin
    if (reset || exc_flush) div_cnt <= '0;
    else if (issue && ds_is_div) div_cnt <= CW'(DIV_CYCLES - 1);
    else if (div_cnt != '0) div_cnt <= div_cnt - 1'b1;
  end

  // saturating count of cycles a valid decode instruction is held
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (ds_valid && ds_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: table-driven scoreboard bench for hazard_sb
module tb_hazard_sb;
  logic clk = 0, reset = 1;
  logic ds_valid = 0, ds_br = 0, ds_reg_write = 0, ds_is_div = 0, mem_data_ok = 0, exc_flush = 0;
  logic [4:0] ds_rs1 = 0, ds_rs2 = 0, ds_rd = 0;
  logic [1:0] ds_lat = 0;
  logic fs_stall, ds_stall, es_stall, es_bubble, fs_flush, ds_flush, es_flush, post_flush;
  logic [31:0] stall_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic rst, valid;
    logic [4:0] rs1, rs2;
    logic br;
    logic [4:0] rd;
    logic rw;
    logic [1:0] lat;
    logic div, mok, fl;
    logic e_ds, e_es, e_bub;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];

  hazard_sb dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_rs1(ds_rs1), .ds_rs2(ds_rs2), .ds_br(ds_br),
    .ds_rd(ds_rd), .ds_reg_write(ds_reg_write), .ds_lat(ds_lat), .ds_is_div(ds_is_div),
    .mem_data_ok(mem_data_ok), .exc_flush(exc_flush), .fs_stall(fs_stall), .ds_stall(ds_stall),
    .es_stall(es_stall), .es_bubble(es_bubble), .fs_flush(fs_flush), .ds_flush(ds_flush),
    .es_flush(es_flush), .post_flush(post_flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic br, input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                     input logic div, input logic mok, input logic fl,
                     input logic e_ds, input logic e_es, input logic e_bub, input logic [31:0] e_cnt);
    vec_t v;
    v = '{rst, valid, rs1, rs2, br, rd, rw, lat, div, mok, fl, e_ds, e_es, e_bub, e_cnt};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; ds_valid = v.valid; ds_rs1 = v.rs1; ds_rs2 = v.rs2; ds_br = v.br;
    ds_rd = v.rd; ds_reg_write = v.rw; ds_lat = v.lat; ds_is_div = v.div;
    mem_data_ok = v.mok; exc_flush = v.fl;
  endtask

  initial begin
    vec_t e;
    int n;
    //   rst v rs1 rs2 br rd rw lat dv mok fl   ds es bub cnt
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // v0 reset state
    add(0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 0, 0);   // v1 load r5
    add(0, 1, 5, 0, 0, 6, 1, 0, 0, 0, 0,  1, 0, 1, 0);   // v2 use at i=0
    add(0, 1, 5, 0, 0, 6, 1, 0, 0, 0, 0,  1, 0, 1, 1);   // v3 i=1
    add(0, 1, 5, 0, 0, 6, 1, 0, 0, 0, 0,  1, 0, 1, 2);   // v4 i=2, data not back
    add(0, 1, 5, 0, 0, 6, 1, 0, 0, 0, 0,  0, 0, 0, 3);   // v5 load retired, issue
    add(0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 0, 3);   // v6 load r5
    add(0, 1, 0, 5, 0, 6, 0, 0, 0, 1, 0,  1, 0, 1, 3);   // v7 i=0 via rs2
    add(0, 1, 0, 5, 0, 6, 0, 0, 0, 1, 0,  1, 0, 1, 4);   // v8 i=1
    add(0, 1, 0, 5, 0, 6, 0, 0, 0, 1, 0,  0, 0, 0, 5);   // v9 i=2, data ok
    add(0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 0, 0, 5);   // v10 alu r3
    add(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 5);   // v11 branch on r3
    add(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);   // v12 branch issues
    add(0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0,  0, 0, 0, 6);   // v13 alu r3
    add(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);   // v14 non-branch: no stall
    add(0, 1, 0, 0, 0, 8, 1, 0, 1, 0, 0,  0, 0, 0, 6);   // v15 div writing r8
    for (int k = 0; k < 7; k++)
      add(0, 1, 8, 0, 1, 9, 1, 0, 0, 0, 0, 1, 1, 0, 32'(6 + k)); // v16-22 div busy + hazard
    add(0, 1, 8, 0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 0, 13);  // v23 issues in cycle 8
    add(0, 1, 0, 0, 0, 7, 1, 1, 0, 0, 0,  0, 0, 0, 13);  // v24 load r7
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 13);  // v25 div
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 13); // v26-28 div_cnt 7..5
    add(0, 1, 0, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0, 13);  // v29 flush at div_cnt=4
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 13);  // v30 divider cleared
    add(0, 1, 0, 0, 0, 7, 1, 1, 0, 0, 0,  0, 0, 0, 13);  // v31 load r7
    add(0, 1, 7, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 13);  // v32 flush over a hazard
    add(0, 1, 7, 11, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 13); // v33 tags gone
    add(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 13);  // v34 load writes r0
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 13);  // v35 r0 reader branch
    add(0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0,  0, 0, 0, 13);  // v36 load r5
    add(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 13);  // v37 stall
    add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 14);  // v38 reset mid-stall
    add(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // v39 after reset
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d.ds_stall", i), 32'(ds_stall), 32'(e.e_ds));
      check($sformatf("v%0d.fs_stall", i), 32'(fs_stall), 32'(e.e_ds));
      check($sformatf("v%0d.es_stall", i), 32'(es_stall), 32'(e.e_es));
      check($sformatf("v%0d.es_bubble", i), 32'(es_bubble), 32'(e.e_bub));
      check($sformatf("v%0d.flushes", i), {28'd0, fs_flush, ds_flush, es_flush, post_flush}, {28'd0, {4{e.fl}}});
      check($sformatf("v%0d.stall_cnt", i), stall_cnt, e.e_cnt);
    end
    // mfc0 has no data-return bypass at its avail stage: two stall cycles
    @(posedge clk);
    #1 drive('{0, 1, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clk);
    #1 drive('{0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!ds_stall) break;
      n++;
    end
    check("cp0_stall_cycles", 32'(n), 32'd2);
    // divider busy window measured directly
    @(posedge clk);
    #1 drive('{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    @(posedge clk);
    #1 ds_valid = 0; ds_is_div = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!es_stall) break;
      n++;
    end
    check("div_busy_cycles", 32'(n), 32'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised scoreboard hazard unit for the multi-stage MIPS pipeline. Unlike a purely combinational comparator, it keeps its own shadow pipeline of destination-register tags, one per post-decode stage. It also owns the multi-cycle divider busy counter. From that state it produces the decode and execute stall, bubble and flush controls, and it counts decode stall cycles for performance tuning.

## Interface
- NSTAGE, 3: tracked post-decode stages. Index 0 = ES, index NSTAGE-1 = last stage before WB.
- REG_W, 5: register index width.
- LOAD_AVAIL, 2: stage index at which load data becomes forwardable. Must be ≤ NSTAGE-1.
- CP0_AVAIL, 2: stage index at which an mfc0 result becomes forwardable. Must be ≤ NSTAGE-1.
- DIV_CYCLES, 8: cycles a div/divu occupies ES. Must be ≥ 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ds_valid  in  1  decode holds a valid instruction.
- ds_rs1, ds_rs2  in  REG_W  source registers. 0 = unused.
- ds_br  in  1  decode instruction is a branch/jump-register resolved in DS.
- ds_rd  in  REG_W  destination register.
- ds_reg_write  in  1  decode instruction writes ds_rd.
- ds_lat  in  2  result class: 0 ALU, 1 LOAD, 2 CP0.
- ds_is_div  in  1  decode instruction is a divide.
- mem_data_ok  in  1  load data for the tag at stage LOAD_AVAIL has returned.
- exc_flush  in  1  exception or eret committed at the last stage.
- fs_stall, ds_stall  out  1  hold fetch/decode.
- es_stall  out  1  hold ES (divider busy).
- es_bubble  out  1  ES loads a bubble this cycle.
- fs_flush, ds_flush, es_flush, post_flush  out  1  kill stage contents.
- stall_cnt  out  32  decode stall cycle counter.

## Operation
- Tag at stage i holds {v, rd, lat}. The avail value is derived from lat: ALU→0, LOAD→LOAD_AVAIL, CP0→CP0_AVAIL.
- Match: source s matches tag i when ds_valid, s≠0, tag v=1 and rd==s.
- Data hazard for a non-branch consumer on a match, when either:
  - i < avail; or
  - i==avail, lat==LOAD and !mem_data_ok.
- Data hazard for a branch consumer (ds_br=1) on a match when i ≤ avail.
- hz = OR of all data hazards over rs1/rs2 and all stages.
- Stall and bubble outputs:
  - es_stall = (div_cnt≠0) && !exc_flush.
  - ds_stall = !exc_flush && (hz || es_stall).
  - fs_stall = ds_stall.
  - es_bubble = hz && !es_stall && !exc_flush.
- Flush outputs: fs_flush = ds_flush = es_flush = post_flush = exc_flush.
- Issue: issue = ds_valid && !ds_stall && !exc_flush.
- Tag pipe update, when !es_stall:
  - tag[i+1] ← tag[i];
  - tag[0] ← {issue && ds_reg_write, ds_rd, ds_lat}.
- Tag pipe update, when es_stall:
  - tag[0] holds;
  - tag[1] ← invalid;
  - tags 2..NSTAGE-1 shift as normal.
- The tag leaving stage NSTAGE-1 is dropped; WB writes the register file write-through.
- Divider counter:
  - issue && ds_is_div loads div_cnt ← DIV_CYCLES-1;
  - otherwise div_cnt decrements while nonzero.
- stall_cnt increments when ds_valid && ds_stall, saturating at 0xFFFF_FFFF.

## Timing
- Reset: all tags invalid, div_cnt=0, stall_cnt=0. With exc_flush=0, every stall/flush/bubble output is 0.
- All outputs are combinational from registered state plus same-cycle inputs. There are no pipeline registers on the outputs.
- Tag and counter updates take effect at the next clk edge.
- exc_flush: next cycle all tags are invalid and div_cnt=0. Stall and bubble outputs are forced 0 in the flush cycle itself. A concurrent decode issue is not recorded.
- A div occupies ES for exactly DIV_CYCLES cycles; es_stall is high for DIV_CYCLES-1 of them.
- Hazard on the same cycle as div busy: es_bubble=0, because ES holds.
- reset dominates exc_flush and all other inputs.
- Register 0 never matches, even if it is written.

## Structure
- Package hazard_sb_pkg holds:
  - lat class constants LAT_ALU/LAT_LOAD/LAT_CP0;
  - the tag struct {v, rd, lat};
  - the avail-lookup function.
- Sub-module hazard_sb_tagpipe implements the NSTAGE tag shift register with hold/bubble insertion at index 0/1.
- Comparator, divider counter and stall counter stay in the top-level block.

## Test plan
- Load-use, non-branch: a LOAD writing r5 issues, next cycle decode reads rs1=r5.
  - Expected: ds_stall=1 and es_bubble=1 for 2 cycles (tag at i=0,1).
  - At i=2 with mem_data_ok=0: stall persists.
  - With mem_data_ok=1: ds_stall=0.
- Branch on ALU result: ALU writing r3, then a branch reading r3.
  - Expected: ds_stall=1 for exactly 1 cycle (i=0).
  - Same case with ds_br=0: no stall.
- Divide: div issues with DIV_CYCLES=8.
  - Expected: es_stall=1 for 7 cycles, ds_stall=1 throughout, es_bubble=0.
  - The next instruction issues in cycle 8.
- Flush mid-divide: exc_flush pulsed at div_cnt=4.
  - Expected: same cycle, all flushes=1 and ds_stall=0.
  - Next cycle: es_stall=0 and all tags invalid; a prior pending load on r7 no longer stalls.
- r0 and reset:
  - An instruction writing r0 followed by a reader of r0: never stalls.
  - Assert reset mid-stall: next cycle stall_cnt=0 and all outputs are 0.
- Counter: decode held for 5 cycles by a hazard.
  - Expected: stall_cnt advances by exactly 5.
